// File: rtl/ram_arbiter_if.sv
// Shared RAM types and the arbiter-to-RAM interface.
// The controller drives address, enables and write data; the RAM answers with load data and a status.
package ram_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_BUSY = 2'd1,
        RAM_DONE = 2'd2
    } ram_state_t;
endpackage

interface ram_if;
    import ram_pkg::*;
    word_t      addr;
    logic [3:0] wen;
    logic       ren;
    word_t      store;
    word_t      load;
    ram_state_t state;

    modport ramctrl (output addr, wen, ren, store, input load, state);
    modport mem     (input addr, wen, ren, store, output load, state);
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-access RAM.
// Round-robin on ties, one outstanding access, per-access timeout with a sticky error flag.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ren,
    input  word_t      i_addr,
    output word_t      i_load,
    output logic       i_ready,
    input  logic       d_ren,
    input  logic [3:0] d_wen,
    input  word_t      d_addr,
    input  word_t      d_store,
    output word_t      d_load,
    output logic       d_ready,
    ram_if.ramctrl     ram,
    output logic       err
);
    localparam int             CW           = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST_CNT     = CW'(TIMEOUT - 1);
    localparam word_t          TIMEOUT_WORD = 32'hDEADBEEF;
    localparam logic           LG_I         = 1'b0;
    localparam logic           LG_D         = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic [3:0]    d_wen_q;
    logic          d_ren_q;
    logic          d_req;
    logic          grant_i;
    logic          grant_d;
    logic          done;
    logic          expire;

    // Request decode and tie-break: on a tie the port not served last wins.
    always_comb begin
        d_req   = d_ren | (|d_wen);
        grant_d = d_req & (~i_ren | (last_grant == LG_I));
        grant_i = i_ren & ~grant_d;
        done    = (ram.state == RAM_DONE);
        expire  = ~done & (cnt == LAST_CNT);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = GRANT_D;
                end else if (grant_i) begin
                    state_next = GRANT_I;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done | expire) begin
                    state_next = RESP;
                end else begin
                    state_next = state;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM bus drive; control is latched at grant so a dropped request still completes.
    always_comb begin
        ram.addr  = 32'h0000_0000;
        ram.store = 32'h0000_0000;
        ram.wen   = 4'b0000;
        ram.ren   = 1'b0;
        case (state)
            GRANT_I: begin
                ram.addr = i_addr;
                ram.ren  = 1'b1;
            end
            GRANT_D: begin
                ram.addr  = d_addr;
                ram.store = d_store;
                ram.wen   = d_wen_q;
                ram.ren   = d_ren_q & ~(|d_wen_q);
            end
            default: begin
                ram.ren = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant bookkeeping, timeout counter and registered responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= LG_I;
            cnt        <= '0;
            err        <= 1'b0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_load     <= 32'h0000_0000;
            d_load     <= 32'h0000_0000;
            d_wen_q    <= 4'b0000;
            d_ren_q    <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (grant_d) begin
                        d_wen_q <= d_wen;
                        d_ren_q <= d_ren;
                    end
                end
                GRANT_I, GRANT_D: begin
                    cnt <= cnt + CW'(1);
                    if (done | expire) begin
                        if (expire) begin
                            err <= 1'b1;
                        end
                        if (state == GRANT_I) begin
                            i_ready    <= 1'b1;
                            i_load     <= done ? ram.load : TIMEOUT_WORD;
                            last_grant <= LG_I;
                        end else begin
                            d_ready    <= 1'b1;
                            d_load     <= done ? ram.load : TIMEOUT_WORD;
                            last_grant <= LG_D;
                        end
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural RAM, per-port expected queues,
// negedge monitor, directed scenarios plus randomized concurrent traffic.
module tb_ram_arbiter;
    import ram_pkg::*;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_ren;
    word_t      i_addr;
    word_t      i_load;
    logic       i_ready;
    logic       d_ren;
    logic [3:0] d_wen;
    word_t      d_addr;
    word_t      d_store;
    word_t      d_load;
    logic       d_ready;
    logic       err;

    ram_if bus ();

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
        .d_load(d_load), .d_ready(d_ready),
        .ram(bus), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  chk;
        word_t data;
    } exp_t;

    int    tests = 0;
    int    fails = 0;
    exp_t  i_q[$];
    exp_t  d_q[$];
    logic  served[$];      // 0 = fetch port, 1 = data port
    word_t ref_dmem[8];
    int    fix_lat;        // 0 selects a random latency of 1..3 per access
    logic  hang;

    function automatic word_t init_val(word_t a);
        return (a == 32'h0000_0100) ? 32'h0000_0013 : {a[15:0], ~a[15:0]};
    endfunction

    function automatic word_t merge(word_t old, word_t st, logic [3:0] be);
        word_t r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? st[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    function automatic logic in_d(word_t a);
        return a[31:5] == 27'h100;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expired(string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Behavioural RAM: answers RAM_DONE after a latency, applies byte-lane writes.
    word_t dmem[8];
    int    rcnt;
    int    rnd_lat;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.state <= RAM_IDLE;
            bus.load  <= 32'h0;
            rcnt      <= 0;
            rnd_lat   <= 2;
            for (int k = 0; k < 8; k++) dmem[k] <= init_val(32'h2000 + 32'(4 * k));
        end else if (bus.state == RAM_DONE) begin
            bus.state <= RAM_IDLE;
            rcnt      <= 0;
            rnd_lat   <= int'($urandom_range(1, 3));
        end else if (bus.ren || bus.wen != 4'b0) begin
            if (!hang && rcnt + 1 >= ((fix_lat != 0) ? fix_lat : rnd_lat)) begin
                bus.state <= RAM_DONE;
                bus.load  <= in_d(bus.addr) ? dmem[bus.addr[4:2]] : init_val(bus.addr);
                if (bus.wen != 4'b0 && in_d(bus.addr))
                    dmem[bus.addr[4:2]] <= merge(dmem[bus.addr[4:2]], bus.store, bus.wen);
            end else begin
                bus.state <= RAM_BUSY;
                rcnt      <= rcnt + 1;
            end
        end else begin
            bus.state <= RAM_IDLE;
            rcnt      <= 0;
        end
    end

    // Monitor: pops the expected queue whenever a port presents ready.
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (i_ready || d_ready) begin
                check("ready_overlap", 32'(i_ready & d_ready), 32'h0);
                check("resp_bus_idle", {27'h0, bus.ren, bus.wen}, 32'h0);
            end
            if (i_ready) begin
                served.push_back(1'b0);
                if (i_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL i_unexpected_ready: got pulse required none");
                end else begin
                    e = i_q.pop_front();
                    if (e.chk) check("i_load", i_load, e.data);
                end
            end
            if (d_ready) begin
                served.push_back(1'b1);
                if (d_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL d_unexpected_ready: got pulse required none");
                end else begin
                    e = d_q.pop_front();
                    if (e.chk) check("d_load", d_load, e.data);
                end
            end
            if (bus.wen != 4'b0) check("write_no_ren", 32'(bus.ren), 32'h0);
        end
    end

    task automatic reset_ref();
        for (int k = 0; k < 8; k++) ref_dmem[k] = init_val(32'h2000 + 32'(4 * k));
    endtask

    task automatic push_d(logic ren, logic [3:0] wen, word_t a, word_t st);
        if (wen != 4'b0) begin
            ref_dmem[a[4:2]] = merge(ref_dmem[a[4:2]], st, wen);
            d_q.push_back('{1'b0, 32'h0});
        end else begin
            d_q.push_back('{ren, ref_dmem[a[4:2]]});
        end
    endtask

    task automatic do_i(word_t a);
        bit seen = 0;
        @(posedge clk); #1;
        i_ren = 1'b1; i_addr = a;
        i_q.push_back('{1'b1, init_val(a)});
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (i_ready) seen = 1;
        end
        if (!seen) expired("i_ready_wait");
        @(posedge clk); #1;
        i_ren = 1'b0;
    endtask

    task automatic do_d(logic ren, logic [3:0] wen, word_t a, word_t st);
        bit seen = 0;
        @(posedge clk); #1;
        d_ren = ren; d_wen = wen; d_addr = a; d_store = st;
        push_d(ren, wen, a, st);
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (d_ready) seen = 1;
        end
        if (!seen) expired("d_ready_wait");
        @(posedge clk); #1;
        d_ren = 1'b0; d_wen = 4'b0;
    endtask

    // Both ports request together; returns ready cycle indices (-1 if never seen).
    task automatic both_req(word_t ia, word_t da, output int ti, output int td);
        ti = -1; td = -1;
        @(posedge clk); #1;
        i_ren = 1'b1; i_addr = ia; d_ren = 1'b1; d_addr = da;
        i_q.push_back('{1'b1, init_val(ia)});
        push_d(1'b1, 4'b0, da, 32'h0);
        for (int n = 0; n < 80 && (ti < 0 || td < 0); n++) begin
            @(negedge clk);
            if (d_ready) td = n;
            if (i_ready) ti = n;
            @(posedge clk); #1;
            if (td >= 0) d_ren = 1'b0;
            if (ti >= 0) i_ren = 1'b0;
        end
        if (ti < 0 || td < 0) expired("both_req_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    ti, td, n, cnt;
        bit    seen;
        word_t fair_d;
        logic [3:0] w;
        rst = 1'b1; i_ren = 1'b0; i_addr = 32'h0; d_ren = 1'b0; d_wen = 4'b0;
        d_addr = 32'h0; d_store = 32'h0; fix_lat = 3; hang = 1'b0;
        reset_ref();
        #12;
        check("rst_i_ready", 32'(i_ready), 32'h0);
        check("rst_d_ready", 32'(d_ready), 32'h0);
        check("rst_i_load", i_load, 32'h0);
        check("rst_d_load", d_load, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ram_en", {27'h0, bus.ren, bus.wen}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // Simultaneous request straight after reset: data first, then fetch.
        both_req(32'h104, 32'h2004, ti, td);
        check("sim_d_first", 32'(td < ti), 32'h1);
        check("sim_gap_cycles", 32'(ti - td), 32'd6);

        // Single fetch with a 3-cycle RAM: 2 + 3 cycles to ready.
        @(posedge clk); #1;
        i_ren = 1'b1; i_addr = 32'h100;
        i_q.push_back('{1'b1, 32'h0000_0013});
        n = 0; seen = 0;
        while (n < 40 && !seen) begin
            @(posedge clk); n++; #1;
            if (i_ready) seen = 1;
        end
        check("fetch_latency", 32'(n), 32'd5);
        check("fetch_d_ready", 32'(d_ready), 32'h0);
        @(posedge clk); #1; i_ren = 1'b0;

        // Partial write, then read it back.
        fix_lat = 2;
        @(posedge clk); #1;
        d_ren = 1'b0; d_wen = 4'b0011; d_addr = 32'h2000; d_store = 32'hAABBCCDD;
        push_d(1'b0, 4'b0011, 32'h2000, 32'hAABBCCDD);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.wen != 4'b0) seen = 1;
        end
        if (!seen) expired("write_issue_wait");
        check("write_wen", 32'(bus.wen), 32'h3);
        check("write_ren", 32'(bus.ren), 32'h0);
        check("write_store", bus.store, 32'hAABBCCDD);
        check("write_addr", bus.addr, 32'h2000);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (d_ready) seen = 1;
        end
        if (!seen) expired("write_ready_wait");
        @(posedge clk); #1; d_wen = 4'b0;
        do_d(1'b1, 4'b0, 32'h2000, 32'h0);

        // Randomized concurrent traffic on both ports.
        fix_lat = 0;
        fork
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    do_i({20'h0, 10'($urandom), 2'b00});
                end
            end
            begin
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    w = 4'($urandom_range(1, 15));
                    case ($urandom_range(0, 2))
                        0:       do_d(1'b1, 4'b0, 32'h2000 + 32'(4 * $urandom_range(0, 7)), 32'h0);
                        1:       do_d(1'b0, w, 32'h2000 + 32'(4 * $urandom_range(0, 7)), $urandom);
                        default: do_d(1'b1, w, 32'h2000 + 32'(4 * $urandom_range(0, 7)), $urandom);
                    endcase
                end
            end
        join

        // Fairness: fetch served last, then both held high for six accesses.
        do_i(32'h110);
        served.delete();
        fair_d = ref_dmem[1];
        @(posedge clk); #1;
        i_ren = 1'b1; i_addr = 32'h10C; d_ren = 1'b1; d_addr = 32'h2004;
        for (int k = 0; k < 3; k++) begin
            i_q.push_back('{1'b1, init_val(32'h10C)});
            d_q.push_back('{1'b1, fair_d});
        end
        cnt = 0;
        for (int k = 0; k < 200 && cnt < 6; k++) begin
            @(negedge clk);
            if (i_ready || d_ready) cnt++;
        end
        if (cnt < 6) expired("fair_wait");
        @(posedge clk); #1; i_ren = 1'b0; d_ren = 1'b0;
        @(negedge clk);
        if (served.size() >= 6) begin
            for (int k = 0; k < 6; k++) check($sformatf("fair_order_%0d", k), 32'(served[k]), 32'((k % 2) == 0));
        end else begin
            expired("fair_served_count");
        end

        // Timeout: RAM never answers.
        check("err_before_timeout", 32'(err), 32'h0);
        hang = 1'b1;
        @(posedge clk); #1;
        i_ren = 1'b1; i_addr = 32'h114;
        i_q.push_back('{1'b1, 32'hDEADBEEF});
        n = 0; seen = 0;
        while (n < 40 && !seen) begin
            @(posedge clk); n++; #1;
            if (i_ready) seen = 1;
        end
        check("timeout_latency", 32'(n), 32'd5);
        check("timeout_err", 32'(err), 32'h1);
        @(posedge clk); #1; i_ren = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("err_sticky", 32'(err), 32'h1);
        check("d_load_hold", d_load, fair_d);

        // Reset while the data port holds the grant.
        @(posedge clk); #1;
        d_ren = 1'b1; d_addr = 32'h2008;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.ren && bus.addr == 32'h2008) seen = 1;
        end
        if (!seen) expired("grant_d_wait");
        #1; rst = 1'b1; d_ren = 1'b0;
        #1;
        check("midrst_ram_en", {27'h0, bus.ren, bus.wen}, 32'h0);
        check("midrst_d_ready", 32'(d_ready), 32'h0);
        check("midrst_i_load", i_load, 32'h0);
        check("midrst_d_load", d_load, 32'h0);
        check("midrst_err", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; hang = 1'b0; fix_lat = 2;
        reset_ref();
        served.delete();
        both_req(32'h118, 32'h200C, ti, td);
        @(negedge clk);
        if (served.size() >= 2) begin
            check("postrst_first_d", 32'(served[0]), 32'h1);
            check("postrst_second_i", 32'(served[1]), 32'h0);
        end else begin
            expired("postrst_served_count");
        end

        repeat (4) @(posedge clk);
        check("i_q_drained", 32'(i_q.size()), 32'h0);
        check("d_q_drained", 32'(d_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
